sid_mix_sched: RTL and testbench
================================

# sid_mix_sched

Sequencer for the SID output mixer. It time-shares one signed 12x9 multiplier across four products per audio sample: voice 1, 2 and 3 amplitude scaling, then master volume. It delivers each mixed sample through a valid/ready handshake. It sits between the three waveform/envelope generators and the audio output path, and is started once per 1 MHz phase-1 enable.

## Interface
Parameters:
- none; all widths are fixed.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- i_start  in  1  one-cycle pulse (1 MHz ph1 enable) requesting a new sample
- i_wave1, i_wave2, i_wave3  in  12  unsigned waveform outputs; 0x800 is midscale
- i_env1, i_env2, i_env3  in  8  unsigned envelope levels
- i_vol  in  4  master volume ($D418[3:0])
- i_voice3_off  in  1  excludes voice 3 from the mix ($D418[7])
- i_ready  in  1  downstream accepts the sample
- o_sample  out  16  signed mixed sample
- o_valid  out  1  o_sample is valid and held
- o_busy  out  1  high in the V1..VOL states
- o_overrun  out  1  sticky; set when an i_start is dropped

## Operation
- States: IDLE, V1, V2, V3, VOL, OUT.
- IDLE:
  - On i_start, snapshot all wave, env, vol and voice3_off inputs into internal registers, then go to V1.
  - Later input changes do not affect the sample in flight.
- Vn state:
  - Multiplier operands: a = snap_waven - 12'h800 (signed), b = {1'b0, snap_envn}.
  - Product is 21-bit signed. term = product >>> 7, an arithmetic floor.
  - term range is -4080..4078. Accumulator is 18-bit signed.
  - V1 loads acc = term.
  - V2 adds its term to acc.
  - V3 adds its term, or adds 0 if snap_voice3_off is set.
  - Max |acc| is 12240, so no overflow or saturation logic is needed.
- VOL state:
  - Multiplier operands: a = acc >>> 3, truncated to 12 bits (range ±1530), b = {5'b0, snap_vol}.
  - o_sample is loaded with the low 16 bits of the product. Range is ±22950, always representable.
  - Sets o_valid and goes to OUT.
- OUT state:
  - o_sample and o_valid are held stable until i_ready is high.
  - On the cycle with o_valid & i_ready, the sample is transferred.
  - After transfer, the next state is V1 if i_start is also high that cycle (with a fresh snapshot). Otherwise it is IDLE.
  - o_valid drops after the transfer edge unless VOL reloads it.
- Dropped starts:
  - i_start in V1, V2, V3 or VOL is ignored and sets o_overrun.
  - i_start in OUT without a same-cycle transfer is also ignored and sets o_overrun.
  - o_overrun is cleared only by rst.

## Timing
- Reset values: state IDLE, o_sample 0, o_valid 0, o_busy 0, o_overrun 0, acc 0.
- Latency: the edge that samples i_start is edge 0. V1, V2, V3 and VOL complete on edges 1 to 4. o_valid is high after edge 4, so minimum start-to-valid is 4 cycles.
- Throughput: one sample per 5 cycles when i_ready is held high. This is far inside the 1 MHz start period at system clock ≥ 5 MHz.
- rst in any state:
  - Aborts the computation and discards the in-flight sample.
  - No o_valid is produced for it.
  - i_start in the reset cycle is ignored.
- Exactly one multiplier product is consumed per state. Multiplier inputs are a combinational mux on state. No multiplier output register.

## Structure
- Shared package holds the state encoding constants, the midscale constant 12'h800, the term shift (7) and the volume pre-shift (3).
- One sub-module: the existing signed `mul_12x9` multiplier, instantiated once.
- Everything else (snapshot registers, accumulator, FSM, handshake) lives in sid_mix_sched.

## Test plan
- wave1=0xFFF, env1=0xFF, wave2=wave3=0x800, vol=0xF, i_ready=1, then pulse start -> o_valid 4 cycles later with o_sample=0x1DD3 (7635).
- All waves=0x000, all envs=0xFF, vol=0xF -> o_sample=0xA65A (-22950). Repeat with voice3_off=1 -> o_sample=0xC43C (-15300).
- Same as the previous case but vol=0 -> o_sample=0x0000 with o_valid still asserted.
- Hold i_ready=0 for 10 cycles after valid and pulse i_start during the wait -> o_valid and o_sample stable throughout, o_overrun=1. Release i_ready -> one transfer, then IDLE.
- Assert i_start in the same cycle as the o_valid & i_ready transfer -> o_valid low the next cycle, new sample valid 4 cycles later, o_overrun stays 0.
- Assert rst while in V2 -> all outputs 0 the next cycle, no spurious o_valid. A following start produces the correct sample.

Source files
------------

// File: rtl/sid_mix_sched_pkg.sv
// Shared constants for the SID mixer sequencer: FSM encoding and
// fixed-point scaling of the voice and volume products.
package sid_mix_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_V1   = 3'd1,
      ST_V2   = 3'd2,
      ST_V3   = 3'd3,
      ST_VOL  = 3'd4,
      ST_OUT  = 3'd5
   } state_t;

   localparam logic [11:0] MIDSCALE   = 12'h800;
   localparam int          TERM_SHIFT = 7;
   localparam int          VOL_SHIFT  = 3;

endpackage

// File: rtl/mul_12x9.sv
// Signed 12x9 multiplier, purely combinational; the full 21-bit product
// is returned so callers can pick their own scaling.
module mul_12x9 (
   input  logic signed [11:0] a,
   input  logic signed [8:0]  b,
   output logic signed [20:0] p
);

   assign p = 21'(a) * 21'(b);

endmodule

// File: rtl/sid_mix_sched.sv
// Mixer sequencer: one shared multiplier scales voices 1..3 by envelope,
// then the sum by master volume, and hands the sample out via valid/ready.
module sid_mix_sched
   import sid_mix_sched_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic [11:0] i_wave1,
   input  logic [11:0] i_wave2,
   input  logic [11:0] i_wave3,
   input  logic [7:0]  i_env1,
   input  logic [7:0]  i_env2,
   input  logic [7:0]  i_env3,
   input  logic [3:0]  i_vol,
   input  logic        i_voice3_off,
   input  logic        i_ready,
   output logic [15:0] o_sample,
   output logic        o_valid,
   output logic        o_busy,
   output logic        o_overrun
);

   state_t             state_reg, state_next;
   logic [11:0]        wave_reg [0:2];
   logic [7:0]         env_reg  [0:2];
   logic [11:0]        wave_in  [0:2];
   logic [7:0]         env_in   [0:2];
   logic [3:0]         vol_reg;
   logic               voice3_off_reg;
   logic signed [17:0] acc_reg;
   logic [15:0]        sample_reg;
   logic               overrun_reg;

   logic               xfer, snap, drop;
   logic signed [11:0] mul_a;
   logic signed [8:0]  mul_b;
   logic signed [20:0] mul_p;
   logic signed [17:0] term;

   assign wave_in[0] = i_wave1;
   assign wave_in[1] = i_wave2;
   assign wave_in[2] = i_wave3;
   assign env_in[0]  = i_env1;
   assign env_in[1]  = i_env2;
   assign env_in[2]  = i_env3;

   assign xfer = (state_reg == ST_OUT) && i_ready;

   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      snap       = 1'b0;
      drop       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (i_start) begin
               snap       = 1'b1;
               state_next = ST_V1;
            end
         end
         ST_V1: begin
            state_next = ST_V2;
            drop       = i_start;
         end
         ST_V2: begin
            state_next = ST_V3;
            drop       = i_start;
         end
         ST_V3: begin
            state_next = ST_VOL;
            drop       = i_start;
         end
         ST_VOL: begin
            state_next = ST_OUT;
            drop       = i_start;
         end
         ST_OUT: begin
            // A start coinciding with the transfer chains straight into V1.
            if (xfer) begin
               if (i_start) begin
                  snap       = 1'b1;
                  state_next = ST_V1;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               drop = i_start;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state_reg)
         ST_V1: begin
            mul_a = $signed(wave_reg[0] - MIDSCALE);
            mul_b = $signed({1'b0, env_reg[0]});
         end
         ST_V2: begin
            mul_a = $signed(wave_reg[1] - MIDSCALE);
            mul_b = $signed({1'b0, env_reg[1]});
         end
         ST_V3: begin
            mul_a = $signed(wave_reg[2] - MIDSCALE);
            mul_b = $signed({1'b0, env_reg[2]});
         end
         ST_VOL: begin
            mul_a = 12'(acc_reg >>> VOL_SHIFT);
            mul_b = $signed({5'b0, vol_reg});
         end
         default: begin
            mul_a = '0;
            mul_b = '0;
         end
      endcase
   end

   mul_12x9 u_mul (
      .a (mul_a),
      .b (mul_b),
      .p (mul_p)
   );

   // Arithmetic shift gives floor division; the result always fits 18 bits.
   assign term = 18'(mul_p >>> TERM_SHIFT);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            wave_reg[i] <= '0;
            env_reg[i]  <= '0;
         end
         vol_reg        <= '0;
         voice3_off_reg <= 1'b0;
      end else if (snap) begin
         for (int i = 0; i < 3; i++) begin
            wave_reg[i] <= wave_in[i];
            env_reg[i]  <= env_in[i];
         end
         vol_reg        <= i_vol;
         voice3_off_reg <= i_voice3_off;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg     <= '0;
         sample_reg  <= '0;
         overrun_reg <= 1'b0;
      end else begin
         if (drop) overrun_reg <= 1'b1;
         case (state_reg)
            ST_V1:   acc_reg <= term;
            ST_V2:   acc_reg <= acc_reg + term;
            ST_V3:   if (!voice3_off_reg) acc_reg <= acc_reg + term;
            ST_VOL:  sample_reg <= mul_p[15:0];
            default: ;
         endcase
      end
   end

   assign o_sample  = sample_reg;
   assign o_valid   = (state_reg == ST_OUT);
   assign o_busy    = (state_reg == ST_V1) || (state_reg == ST_V2) ||
                      (state_reg == ST_V3) || (state_reg == ST_VOL);
   assign o_overrun = overrun_reg;

endmodule

// File: tb/tb_sid_mix_sched.sv
// Self-checking bench for sid_mix_sched: directed cases plus randomized
// samples compared against an arithmetic reference of the mix equation.
module tb_sid_mix_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [11:0] i_wave1, i_wave2, i_wave3;
   logic [7:0]  i_env1, i_env2, i_env3;
   logic [3:0]  i_vol;
   logic        i_voice3_off;
   logic        i_ready;
   logic [15:0] o_sample;
   logic        o_valid;
   logic        o_busy;
   logic        o_overrun;

   int   errors = 0;
   int   checks = 0;
   logic ovr_exp;

   always #5 clk = ~clk;

   sid_mix_sched dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (i_start),
      .i_wave1      (i_wave1),
      .i_wave2      (i_wave2),
      .i_wave3      (i_wave3),
      .i_env1       (i_env1),
      .i_env2       (i_env2),
      .i_env3       (i_env3),
      .i_vol        (i_vol),
      .i_voice3_off (i_voice3_off),
      .i_ready      (i_ready),
      .o_sample     (o_sample),
      .o_valid      (o_valid),
      .o_busy       (o_busy),
      .o_overrun    (o_overrun)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Floor division for a positive divisor, independent of the sign of n.
   function automatic int floor_div(input int n, input int d);
      if (n >= 0) return n / d;
      return -((-n + d - 1) / d);
   endfunction

   function automatic logic [15:0] model(input logic [11:0] w1, input logic [11:0] w2,
                                         input logic [11:0] w3, input logic [7:0] e1,
                                         input logic [7:0] e2, input logic [7:0] e3,
                                         input logic [3:0] vol, input logic v3off);
      int acc;
      acc = floor_div((int'(w1) - 2048) * int'(e1), 128)
          + floor_div((int'(w2) - 2048) * int'(e2), 128);
      if (!v3off) acc += floor_div((int'(w3) - 2048) * int'(e3), 128);
      return 16'(floor_div(acc, 8) * int'(vol));
   endfunction

   task automatic set_in(input logic [11:0] w1, input logic [11:0] w2, input logic [11:0] w3,
                         input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3,
                         input logic [3:0] vol, input logic v3off);
      i_wave1 = w1; i_wave2 = w2; i_wave3 = w3;
      i_env1  = e1; i_env2  = e2; i_env3  = e3;
      i_vol   = vol; i_voice3_off = v3off;
   endtask

   task automatic scramble();
      set_in(12'($urandom), 12'($urandom), 12'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), 4'($urandom), 1'($urandom));
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ovr_exp = 1'b0;
   endtask

   // drop: 0 none, 1 extra start while computing, 2 extra start while stalled in OUT
   task automatic do_sample(input string tag, input logic [15:0] exp, input int stall, input int drop);
      i_ready = (stall == 0);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      scramble();
      if (drop == 1) begin
         i_start = 1'b1;
         ovr_exp = 1'b1;
      end
      tick();
      i_start = 1'b0;
      tick();
      tick();
      check({tag, "/valid_early"}, 32'(o_valid), 32'd0);
      check({tag, "/busy"}, 32'(o_busy), 32'd1);
      tick();
      check({tag, "/valid"}, 32'(o_valid), 32'd1);
      check({tag, "/sample"}, 32'(o_sample), 32'(exp));
      for (int k = 0; k < stall; k++) begin
         if (drop == 2 && k == 3) begin
            i_start = 1'b1;
            ovr_exp = 1'b1;
         end
         tick();
         i_start = 1'b0;
         check({tag, "/hold_valid"}, 32'(o_valid), 32'd1);
         check({tag, "/hold_sample"}, 32'(o_sample), 32'(exp));
      end
      i_ready = 1'b1;
      tick();
      check({tag, "/after_xfer"}, 32'(o_valid), 32'd0);
      check({tag, "/idle"}, 32'(o_busy), 32'd0);
      check({tag, "/overrun"}, 32'(o_overrun), 32'(ovr_exp));
      $display("%s: sample=0x%04h expected=0x%04h stall=%0d drop=%0d overrun=%0b",
               tag, o_sample, exp, stall, drop, o_overrun);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] exp;
      int          stall, drop;

      rst = 1'b1; i_start = 1'b0; i_ready = 1'b1; ovr_exp = 1'b0;
      set_in(12'h0, 12'h0, 12'h0, 8'h0, 8'h0, 8'h0, 4'h0, 1'b0);
      tick();
      tick();
      check("rst/sample", 32'(o_sample), 32'd0);
      check("rst/valid", 32'(o_valid), 32'd0);
      check("rst/busy", 32'(o_busy), 32'd0);
      check("rst/overrun", 32'(o_overrun), 32'd0);
      rst = 1'b0;
      tick();

      set_in(12'hFFF, 12'h800, 12'h800, 8'hFF, 8'hFF, 8'hFF, 4'hF, 1'b0);
      do_sample("v1_max", 16'h1DD3, 0, 0);
      set_in(12'h000, 12'h000, 12'h000, 8'hFF, 8'hFF, 8'hFF, 4'hF, 1'b0);
      do_sample("all_min", 16'hA65A, 0, 0);
      set_in(12'h000, 12'h000, 12'h000, 8'hFF, 8'hFF, 8'hFF, 4'hF, 1'b1);
      do_sample("v3_off", 16'hC43C, 0, 0);
      set_in(12'h000, 12'h000, 12'h000, 8'hFF, 8'hFF, 8'hFF, 4'h0, 1'b1);
      do_sample("vol_zero", 16'h0000, 0, 0);

      set_in(12'hFFF, 12'h800, 12'h800, 8'hFF, 8'hFF, 8'hFF, 4'hF, 1'b0);
      do_sample("stall", 16'h1DD3, 10, 2);
      tick();
      check("stall/stay_idle", 32'(o_valid), 32'd0);

      // Back-to-back: start in the transfer cycle chains a new sample.
      reset_dut();
      set_in(12'hFFF, 12'h800, 12'h800, 8'hFF, 8'hFF, 8'hFF, 4'hF, 1'b0);
      i_ready = 1'b1;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      repeat (4) tick();
      check("b2b/first_valid", 32'(o_valid), 32'd1);
      check("b2b/first_sample", 32'(o_sample), 32'h1DD3);
      set_in(12'h000, 12'h000, 12'h000, 8'hFF, 8'hFF, 8'hFF, 4'hF, 1'b0);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      check("b2b/valid_drop", 32'(o_valid), 32'd0);
      check("b2b/busy", 32'(o_busy), 32'd1);
      repeat (3) tick();
      check("b2b/valid_early", 32'(o_valid), 32'd0);
      tick();
      check("b2b/second_valid", 32'(o_valid), 32'd1);
      check("b2b/second_sample", 32'(o_sample), 32'hA65A);
      check("b2b/overrun", 32'(o_overrun), 32'd0);
      tick();
      check("b2b/after_xfer", 32'(o_valid), 32'd0);
      $display("b2b: samples 0x1DD3 then 0xA65A chained");

      // Reset while in V2, with a start asserted during the reset cycle.
      set_in(12'hFFF, 12'h800, 12'h800, 8'hFF, 8'hFF, 8'hFF, 4'hF, 1'b0);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      check("rst_v2/busy_before", 32'(o_busy), 32'd1);
      rst = 1'b1;
      i_start = 1'b1;
      tick();
      rst = 1'b0;
      i_start = 1'b0;
      check("rst_v2/sample", 32'(o_sample), 32'd0);
      check("rst_v2/valid", 32'(o_valid), 32'd0);
      check("rst_v2/busy", 32'(o_busy), 32'd0);
      check("rst_v2/overrun", 32'(o_overrun), 32'd0);
      for (int k = 0; k < 6; k++) begin
         tick();
         check("rst_v2/no_valid", 32'(o_valid), 32'd0);
      end
      $display("rst_v2: in-flight sample discarded");
      ovr_exp = 1'b0;
      do_sample("post_rst", 16'h1DD3, 0, 0);

      reset_dut();
      for (int n = 0; n < 40; n++) begin
         scramble();
         exp   = model(i_wave1, i_wave2, i_wave3, i_env1, i_env2, i_env3, i_vol, i_voice3_off);
         stall = int'($urandom_range(0, 6));
         drop  = int'($urandom_range(0, 2));
         do_sample("rnd", exp, stall, drop);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
